// File: rtl/hilo_div_seq_pkg.sv
// Shared types and defaults for the HI/LO divide sequencer.
package hilo_div_seq_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int DIV_CYCLES_DEF = 32;

  // Sequencer states: waiting for work, pulsing DControl, counting the divider.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Counter width able to hold DIV_CYCLES-1 with a spare bit.
  function automatic int cnt_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/hilo_div_seq_if.sv
// Control-unit / divider side signals of the HI/LO sequencer.
//
// Handshake: div_req is a level request that is accepted only when the
// sequencer is idle (busy low); a request seen while busy is dropped, not
// queued. done or div0_exc pulses for one cycle to close each accepted request.
interface hilo_div_seq_if
  import hilo_div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
);

  logic             div_req;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             div0_in;

  logic             dcontrol;
  logic             busy;
  logic             done;
  logic             div0_exc;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Debug view of the sequencer internals.
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport slave (
    input  div_req, mthi, mtlo, wr_data, div_hi, div_lo, div0_in,
    output dcontrol, busy, done, div0_exc, hi, lo, dbg_state, dbg_cnt
  );

  modport master (
    output div_req, mthi, mtlo, wr_data, div_hi, div_lo, div0_in,
    input  dcontrol, busy, done, div0_exc, hi, lo, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/hilo_div_seq.sv
// HI/LO register bank and divide sequencer: starts the iterative divider with
// a one-cycle DControl pulse, waits its fixed latency, then captures the
// quotient/remainder into HI/LO. Also services MTHI/MTLO while idle.
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  hilo_div_seq_if.slave  bus
);

  localparam int               CNT_W    = cnt_w(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state,    w_state;
  logic [CNT_W-1:0] r_cnt,      w_cnt;
  logic             r_first,    w_first;
  logic             r_dcontrol, w_dcontrol;
  logic             r_busy,     w_busy;
  logic             r_done,     w_done;
  logic             r_div0_exc, w_div0_exc;
  logic [WIDTH-1:0] r_hi,       w_hi;
  logic [WIDTH-1:0] r_lo,       w_lo;

  // State and output registers; reset drops any divide in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_dcontrol <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div0_exc <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_first    <= w_first;
      r_dcontrol <= w_dcontrol;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_div0_exc <= w_div0_exc;
      r_hi       <= w_hi;
      r_lo       <= w_lo;
    end
  end

  // Next-state and next-output logic; pulses default low so they last one cycle.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_first    = 1'b0;
    w_dcontrol = 1'b0;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_div0_exc = 1'b0;
    w_hi       = r_hi;
    w_lo       = r_lo;

    case (r_state)
      ST_IDLE: begin
        // Moves to HI/LO land at this edge even if a divide starts with them;
        // the divide result overwrites them later.
        if (bus.mthi) w_hi = bus.wr_data;
        if (bus.mtlo) w_lo = bus.wr_data;
        if (bus.div_req) begin
          w_state    = ST_START;
          w_dcontrol = 1'b1;
          w_busy     = 1'b1;
        end
      end

      ST_START: begin
        // Divider loads operands at this edge; DControl must fall now since
        // the divider reloads on every cycle it is high.
        w_state = ST_WAIT;
        w_cnt   = CNT_LAST;
        w_first = 1'b1;
      end

      ST_WAIT: begin
        if (r_first && bus.div0_in) begin
          // Divide by zero is flagged right after the load; HI/LO untouched.
          w_state    = ST_IDLE;
          w_div0_exc = 1'b1;
          w_busy     = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else begin
          w_state = ST_IDLE;
          w_hi    = bus.div_hi;
          w_lo    = bus.div_lo;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign bus.dcontrol  = r_dcontrol;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.div0_exc  = r_div0_exc;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;
  assign bus.dbg_cnt   = r_cnt;

endmodule
